// File: rtl/bm2a_pkg.sv
// Shared definitions for the b - 2a sequencer: datapath width and FSM state encoding.
package bm2a_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    CALC  = 2'b10,
    HOLD  = 2'b11
  } state_e;

endpackage : bm2a_pkg

// File: rtl/b_minus_2a.sv
// Combinational arithmetic stage: o = b - 2a - cin (mod 2^DATA_W); cout flags a[MSB] or no borrow.
module b_minus_2a
  import bm2a_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] o,
  output logic              cout
);

  logic [DATA_W-1:0] a2_s;
  logic [DATA_W:0]   diff_s;

  assign a2_s   = {a[DATA_W-2:0], 1'b0};
  assign diff_s = {1'b0, b} - {1'b0, a2_s} - {{DATA_W{1'b0}}, cin};
  assign o      = diff_s[DATA_W-1:0];
  // The MSB of a is shifted out by the doubling, so it forces the carry flag.
  assign cout   = a[DATA_W-1] | ~diff_s[DATA_W];

endmodule : b_minus_2a

// File: rtl/bm2a_sequencer.sv
// Collects operands a and b, registers (b - 2a) with a carry flag, and holds the result
// until the downstream handshake; counts accepted results.
module bm2a_sequencer
  import bm2a_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_cout_q, out_cout_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic [DATA_W-1:0] calc_o_s;
  logic              calc_cout_s;
  logic              in_fire_s;

  b_minus_2a u_calc (
    .a    (a_q),
    .b    (b_q),
    .cin  (1'b0),
    .o    (calc_o_s),
    .cout (calc_cout_s)
  );

  assign in_ready  = (state_q == GET_A) || (state_q == GET_B);
  assign busy      = (state_q != GET_A);
  assign in_fire_s = in_valid & in_ready;

  // Next-state and register updates; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_data_d  = out_data_q;
    out_cout_d  = out_cout_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
    if (flush) begin
      state_d     = GET_A;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (in_fire_s) begin
            a_d     = in_data;
            state_d = GET_B;
          end else begin
            state_d = GET_A;
          end
        end
        GET_B: begin
          if (in_fire_s) begin
            b_d     = in_data;
            state_d = CALC;
          end else begin
            state_d = GET_B;
          end
        end
        CALC: begin
          out_data_d  = calc_o_s;
          out_cout_d  = calc_cout_s;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            op_count_d  = op_count_q + CNT_W'(1);
            state_d     = GET_A;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d     = GET_A;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, operand, result and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GET_A;
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_data_q  <= out_data_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_cout  = out_cout_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;

endmodule : bm2a_sequencer

// File: tb/tb_bm2a_sequencer.sv
// Directed and randomized bench for bm2a_sequencer against a transaction-level model.
module tb_bm2a_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] out_data;
  logic        out_cout;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [7:0]  op_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_cout = 1'b0;

  bm2a_sequencer #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples land 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result computed from plain integer arithmetic.
  task automatic ref_calc(input int unsigned a, input int unsigned b,
                          output logic [15:0] d, output logic c);
    int unsigned two_a;
    two_a = 2 * a;
    d = 16'((b + 131072 - two_a) % 65536);
    c = (a >= 32768) || (b >= (two_a % 65536));
  endtask

  task automatic send_word(input logic [15:0] w);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("in_ready_timeout", 32'(in_ready), 32'(1));
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // One full operation; delay = cycles out_ready stays low in HOLD (0 = already high).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int delay, input bit full);
    ref_calc(a, b, exp_data, exp_cout);
    out_ready = (delay == 0);
    send_word(a);
    send_word(b);
    if (full) begin
      chk("calc_out_valid_low", 32'(out_valid), 32'(0));
      chk("calc_in_ready_low", 32'(in_ready), 32'(0));
      chk("calc_busy", 32'(busy), 32'(1));
    end
    step();
    chk("hold_out_valid", 32'(out_valid), 32'(1));
    chk("out_data", 32'(out_data), 32'(exp_data));
    chk("out_cout", 32'(out_cout), 32'(exp_cout));
    for (int i = 0; i < delay; i++) begin
      step();
      chk("hold_stable_valid", 32'(out_valid), 32'(1));
      chk("hold_stable_data", 32'(out_data), 32'(exp_data));
      chk("hold_stable_cout", 32'(out_cout), 32'(exp_cout));
      chk("hold_in_ready_low", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    chk("accept_out_valid_low", 32'(out_valid), 32'(0));
    chk("accept_in_ready", 32'(in_ready), 32'(1));
    chk("op_count", 32'(op_count), 32'(exp_count));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_data"}, 32'(out_data), 32'(0));
    chk({tag, "_out_cout"}, 32'(out_cout), 32'(0));
    chk({tag, "_op_count"}, 32'(op_count), 32'(0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  // Asynchronous reset pulse placed mid-cycle, released before the next edge.
  task automatic reset_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    check_reset_vals(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 16'h0000;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #3;
    check_reset_vals("por");
    #10;
    rst_n = 1'b1;
    #1;

    // Worked examples.
    run_op(16'h0003, 16'h0010, 0, 1'b1);
    chk("ex1_data", 32'(out_data), 32'h000A);
    chk("ex1_cout", 32'(out_cout), 32'(1));
    chk("ex1_count", 32'(op_count), 32'(1));
    run_op(16'h0008, 16'h0004, 1, 1'b1);
    chk("ex2_data", 32'(out_data), 32'hFFF4);
    chk("ex2_cout", 32'(out_cout), 32'(0));
    run_op(16'h8001, 16'h0000, 0, 1'b1);
    chk("ex3_data", 32'(out_data), 32'hFFFE);
    chk("ex3_cout", 32'(out_cout), 32'(1));

    // Backpressure for 5 cycles.
    run_op(16'h1234, 16'h4321, 5, 1'b1);

    // Flush one cycle after a, with b offered at the same time.
    send_word(16'h0777);
    in_data  = 16'h0999;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", 32'(busy), 32'(0));
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    chk("flush_count", 32'(op_count), 32'(exp_count));
    chk("flush_keeps_data", 32'(out_data), 32'(exp_data));
    step();
    chk("flush_no_stray_valid", 32'(out_valid), 32'(0));
    run_op(16'h0001, 16'h0005, 0, 1'b1);
    chk("after_flush_data", 32'(out_data), 32'h0003);

    // Flush in HOLD with out_ready high: no count, result registers kept.
    out_ready = 1'b0;
    send_word(16'h0010);
    send_word(16'h0100);
    step();
    ref_calc(16'h0010, 16'h0100, exp_data, exp_cout);
    chk("pre_flush_hold_valid", 32'(out_valid), 32'(1));
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("hold_flush_valid", 32'(out_valid), 32'(0));
    chk("hold_flush_count", 32'(op_count), 32'(exp_count));
    chk("hold_flush_data", 32'(out_data), 32'(exp_data));
    chk("hold_flush_cout", 32'(out_cout), 32'(exp_cout));

    // Reset in GET_B, then in HOLD.
    send_word(16'h0042);
    chk("in_get_b_busy", 32'(busy), 32'(1));
    reset_pulse("rst_getb");
    step();
    chk("rst_getb_no_valid", 32'(out_valid), 32'(0));
    run_op(16'h0002, 16'h0009, 0, 1'b0);
    send_word(16'h0004);
    send_word(16'h0040);
    step();
    chk("pre_rst_hold_valid", 32'(out_valid), 32'(1));
    reset_pulse("rst_hold");
    step();
    chk("rst_hold_no_valid", 32'(out_valid), 32'(0));
    chk("rst_hold_in_ready", 32'(in_ready), 32'(1));

    // Randomized operands and backpressure.
    for (int i = 0; i < 24; i++) begin
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b1);
    end

    // 256 back-to-back operations from a cleared counter wrap it to zero.
    reset_pulse("rst_wrap");
    step();
    for (int i = 0; i < 256; i++) begin
      run_op(16'($urandom), 16'($urandom), 0, 1'b0);
    end
    chk("wrap_count", 32'(op_count), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bm2a_sequencer
